// File: rtl/ctl_rcv_sync_if.sv
// Bundle of the async req/ack handshake and the valid/ready FIFO output.
// slave: the receiver (ctl_rcv_sync). master: the async sender plus the consumer.
interface ctl_rcv_sync_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  logic                   req_i;
  logic [WIDTH-1:0]       data_i;
  logic                   ack_o;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  logic                   out_ready;
  logic [$clog2(DEPTH):0] count;

  modport slave (
    input  req_i, data_i, out_ready,
    output ack_o, out_valid, out_data, count
  );

  modport master (
    output req_i, data_i, out_ready,
    input  ack_o, out_valid, out_data, count
  );
endinterface

// File: rtl/ctl_rcv_sync.sv
// Clocked receiver for a 4-phase bundled-data handshake, feeding a show-ahead FIFO.
//
// state | meaning
// INIT  | after reset; waits for the synchronized request to be seen low
// IDLE  | ack low, waiting for a request (held off while the FIFO is full)
// ACKH  | word captured, ack high, waiting for the request to return to zero
module ctl_rcv_sync #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  ctl_rcv_sync_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {INIT, IDLE, ACKH} state_t;

  state_t                 state_q, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic [TW-1:0]          init_cnt_q;
  logic                   ack_q, ack_nxt;
  logic                   push, pop, full_blk;
  logic [WIDTH-1:0]       mem [DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q, rd_inc;
  logic [CW-1:0]          count_q, count_nxt;
  logic                   valid_q;
  logic [WIDTH-1:0]       head_q, head_nxt;

  assign req_s = sync_q[SYNC_STAGES-1];

  // Request synchronizer; req_i is never used anywhere else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.req_i};
  end

  // INIT settle timer: the chain is cleared by reset, so req_s is only
  // trustworthy once SYNC_STAGES edges have refilled it. Without this a
  // request held high through reset would look like a fresh rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  init_cnt_q <= TW'(SYNC_STAGES);
    else if (state_q == INIT && init_cnt_q != 0) init_cnt_q <= init_cnt_q - 1'b1;
  end

  assign pop      = (count_q != '0) && bus.out_ready;
  // A same-edge pop frees a slot, so a full FIFO can still accept.
  assign full_blk = (count_q == CW'(DEPTH)) && !pop;

  // Handshake FSM: next state, ack and capture strobe.
  always_comb begin
    state_nxt = state_q;
    ack_nxt   = ack_q;
    push      = 1'b0;
    case (state_q)
      INIT: begin
        ack_nxt = 1'b0;
        if (init_cnt_q == '0 && !req_s) state_nxt = IDLE;
      end
      IDLE: begin
        ack_nxt = 1'b0;
        if (req_s && !full_blk) begin
          push      = 1'b1;
          ack_nxt   = 1'b1;
          state_nxt = ACKH;
        end
      end
      ACKH: begin
        ack_nxt = 1'b1;
        if (!req_s) begin
          ack_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        ack_nxt   = 1'b0;
        state_nxt = INIT;
      end
    endcase
  end

  // FSM state and registered (glitch-free) acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      ack_q   <= ack_nxt;
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.data_i;
  end

  assign rd_inc = rd_ptr_q + 1'b1;

  // Next head word and occupancy; the head register holds its last value when empty.
  always_comb begin
    head_nxt  = head_q;
    count_nxt = count_q;
    if (pop && count_q > CW'(1))
      head_nxt = mem[rd_inc];
    else if (push && (count_q == '0 || (pop && count_q == CW'(1))))
      head_nxt = bus.data_i;
    if (push && !pop)      count_nxt = count_q + 1'b1;
    else if (pop && !push) count_nxt = count_q - 1'b1;
  end

  // FIFO pointers, count and registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_inc;
      count_q <= count_nxt;
      valid_q <= (count_nxt != '0);
      head_q  <= head_nxt;
    end
  end

  assign bus.ack_o     = ack_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = head_q;
  assign bus.count     = count_q;
endmodule

// File: tb/tb_ctl_rcv_sync.sv
// Bench for ctl_rcv_sync: protocol-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ctl_rcv_sync;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int S     = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   errors  = 0;

  ctl_rcv_sync_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  ctl_rcv_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: req is seen S edges late; a request already high when
  // the receiver wakes is ignored until it has been seen low; one word per
  // 4-phase cycle; FIFO is a queue bounded by DEPTH.
  logic [WIDTH-1:0] mq[$];
  logic             hist[S];
  logic             m_ack;
  logic [WIDTH-1:0] m_last;
  int               m_phase;   // 0 waking, 1 waiting for request, 2 acknowledged
  int               m_edges;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ack   = 1'b0;
      m_last  = '0;
      m_phase = 0;
      m_edges = 0;
      for (int i = 0; i < S; i++) hist[i] = 1'b0;
    end else begin
      logic seen_req, m_pop, m_push;
      seen_req = hist[S-1];
      for (int i = S - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = bus.req_i;
      m_edges++;
      m_pop  = (mq.size() > 0) && bus.out_ready;
      m_push = 1'b0;
      if (m_phase == 0) begin
        if (m_edges > S && !seen_req) m_phase = 1;
      end else if (m_phase == 1) begin
        if (seen_req && (mq.size() - int'(m_pop) < DEPTH)) begin
          m_push  = 1'b1;
          m_ack   = 1'b1;
          m_phase = 2;
        end
      end else begin
        if (!seen_req) begin
          m_ack   = 1'b0;
          m_phase = 1;
        end
      end
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(bus.data_i);
      if (mq.size() > 0) m_last = mq[0];
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("ack_o", int'(bus.ack_o), int'(m_ack));
    chk("out_valid", int'(bus.out_valid), int'(mq.size() > 0));
    chk("out_data", int'(bus.out_data), int'(m_last));
    chk("count", int'(bus.count), mq.size());
  end

  // Words actually handed to the consumer.
  logic [WIDTH-1:0] rx[$];
  always @(posedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) rx.push_back(bus.out_data);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ack(input logic val, output int n);
    n = 0;
    while (bus.ack_o !== val && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic send(input logic [WIDTH-1:0] w);
    int n;
    bus.data_i = w;
    bus.req_i  = 1'b1;
    wait_ack(1'b1, n);
    chk("send_ack_rise", int'(bus.ack_o), 1);
    bus.req_i = 1'b0;
    wait_ack(1'b0, n);
    chk("send_ack_fall", int'(bus.ack_o), 0);
  endtask

  task automatic chk_rx(input string name, input logic [WIDTH-1:0] exp[$]);
    chk({name, "_len"}, rx.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rx.size(); i++)
      chk(name, int'(rx[i]), int'(exp[i]));
    rx.delete();
  endtask

  initial begin
    int n;
    logic [WIDTH-1:0] exp_q[$];
    bus.req_i     = 1'b0;
    bus.data_i    = '0;
    bus.out_ready = 1'b0;
    tick(2);
    chk("rst_ack", int'(bus.ack_o), 0);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_data", int'(bus.out_data), 0);
    rst_n = 1'b1;
    tick(5);

    // Single token: latency both ways is S+1 edges.
    bus.data_i = 8'hA5;
    bus.req_i  = 1'b1;
    wait_ack(1'b1, n);
    chk("rise_latency", n, 3);
    chk("single_data", int'(bus.out_data), 8'hA5);
    chk("single_valid", int'(bus.out_valid), 1);
    chk("single_count", int'(bus.count), 1);
    bus.req_i = 1'b0;
    wait_ack(1'b0, n);
    chk("fall_latency", n, 3);
    bus.out_ready = 1'b1;
    tick(1);
    bus.out_ready = 1'b0;
    exp_q = '{8'hA5};
    chk_rx("single_rx", exp_q);

    // Fill and backpressure.
    for (int i = 1; i <= 4; i++) send(WIDTH'(i));
    chk("full_count", int'(bus.count), 4);
    bus.data_i = 8'h05;
    bus.req_i  = 1'b1;
    tick(10);
    chk("bp_ack_low", int'(bus.ack_o), 0);
    bus.out_ready = 1'b1;
    tick(1);
    bus.out_ready = 1'b0;
    chk("bp_ack_high", int'(bus.ack_o), 1);
    chk("bp_count", int'(bus.count), 4);
    chk("bp_head", int'(bus.out_data), 8'h02);
    bus.req_i = 1'b0;
    wait_ack(1'b0, n);
    bus.out_ready = 1'b1;
    tick(4);
    bus.out_ready = 1'b0;
    chk("drain_count", int'(bus.count), 0);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    chk_rx("fill_rx", exp_q);

    // Push and pop on the same edge at count=1.
    send(8'h40);
    bus.data_i = 8'h41;
    bus.req_i  = 1'b1;
    tick(2);
    bus.out_ready = 1'b1;
    tick(1);
    bus.out_ready = 1'b0;
    chk("pp_ack", int'(bus.ack_o), 1);
    chk("pp_count", int'(bus.count), 1);
    chk("pp_head", int'(bus.out_data), 8'h41);
    bus.req_i = 1'b0;
    wait_ack(1'b0, n);
    bus.out_ready = 1'b1;
    tick(2);
    bus.out_ready = 1'b0;
    exp_q = '{8'h40, 8'h41};
    chk_rx("pp_rx", exp_q);

    // Streaming with pointer wrap.
    bus.out_ready = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      send(WIDTH'(8'h10 + i));
      exp_q.push_back(WIDTH'(8'h10 + i));
    end
    tick(3);
    bus.out_ready = 1'b0;
    chk("wrap_count", int'(bus.count), 0);
    chk("wrap_valid", int'(bus.out_valid), 0);
    chk_rx("wrap_rx", exp_q);

    // Reset while acknowledged with two words held.
    send(8'h50);
    bus.data_i = 8'h51;
    bus.req_i  = 1'b1;
    wait_ack(1'b1, n);
    chk("mid_count", int'(bus.count), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", int'(bus.ack_o), 0);
    chk("mid_rst_count", int'(bus.count), 0);
    chk("mid_rst_valid", int'(bus.out_valid), 0);
    tick(3);
    rst_n = 1'b1;
    tick(20);
    chk("stale1_ack", int'(bus.ack_o), 0);
    chk("stale1_count", int'(bus.count), 0);
    bus.req_i = 1'b0;
    tick(5);
    send(8'h3C);
    bus.out_ready = 1'b1;
    tick(2);
    bus.out_ready = 1'b0;
    exp_q = '{8'h3C};
    chk_rx("mid_rx", exp_q);

    // Request held high through a reset release.
    #2 rst_n = 1'b0;
    bus.req_i = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(20);
    chk("stale2_ack", int'(bus.ack_o), 0);
    chk("stale2_count", int'(bus.count), 0);
    bus.req_i = 1'b0;
    tick(5);
    send(8'h77);
    bus.out_ready = 1'b1;
    tick(2);
    bus.out_ready = 1'b0;
    exp_q = '{8'h77};
    chk_rx("stale_rx", exp_q);

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
